// File: rtl/control_unit_pkg.sv
// Shared states, opcode and ALU-function encodings for the control_unit FSM.
package control_unit_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_FETCH2,
        S_OPRD,
        S_ALU,
        S_WB,
        S_MEMWR,
        S_BR,
        S_HALT
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_ALUR = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JN   = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOTA  = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    function automatic logic is_jump(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JC) || (op == OP_JZ) || (op == OP_JN);
    endfunction

endpackage

// File: rtl/cu_branch_eval.sv
// Branch-taken decision for JMP/JC/JZ/JN from the opcode and the C/Z/N flags.
module cu_branch_eval
    import control_unit_pkg::*;
(
    input  logic [3:0] ir_op_i,
    input  logic [2:0] czn_i,
    output logic       take_o
);

    always_comb begin
        take_o = 1'b0;
        case (ir_op_i)
            OP_JMP:  take_o = 1'b1;
            OP_JC:   take_o = czn_i[2];
            OP_JZ:   take_o = czn_i[1];
            OP_JN:   take_o = czn_i[0];
            default: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore-style multi-cycle control FSM for a simple accumulator datapath.
// Optional retired-instruction counter enabled by CONTROL_UNIT_RETIRE_CNT_EN.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          ir_op,
    input  logic [4:0]          di_op,
    input  logic [2:0]          czn,
    output logic                pc_inc,
    output logic                pc_ld,
    output logic                ir_ld,
    output logic                tr_ld,
    output logic                a_ld,
    output logic                b_ld,
    output logic                res_ld,
    output logic                czn_ld,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                acc_wr,
    output logic                addr_sel,
    output logic                b_src_sel,
    output logic                a_zero,
    output logic                b_zero,
    output logic [2:0]          alu_op,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retire_cnt
);

    state_e state_q, state_d;
    logic   br_take;
    logic   unused_di;

    assign unused_di = ^di_op[4:3];

    cu_branch_eval u_branch_eval (
        .ir_op_i (ir_op),
        .czn_i   (czn),
        .take_o  (br_take)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pc_inc    = 1'b0;
        pc_ld     = 1'b0;
        ir_ld     = 1'b0;
        tr_ld     = 1'b0;
        a_ld      = 1'b0;
        b_ld      = 1'b0;
        res_ld    = 1'b0;
        czn_ld    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        acc_wr    = 1'b0;
        addr_sel  = 1'b0;
        b_src_sel = 1'b0;
        a_zero    = 1'b0;
        b_zero    = 1'b0;
        alu_op    = ALU_ADD;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd  = 1'b1;
                ir_ld   = 1'b1;
                pc_inc  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ir_op)
                    OP_NOP:  state_d = S_FETCH;
                    OP_ALUR: state_d = S_OPRD;
                    OP_HLT:  state_d = S_HALT;
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND,
                    OP_JMP, OP_JC, OP_JZ, OP_JN: state_d = S_FETCH2;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_FETCH2: begin
                mem_rd  = 1'b1;
                tr_ld   = 1'b1;
                pc_inc  = 1'b1;
                state_d = is_jump(ir_op) ? S_BR : S_OPRD;
            end
            S_OPRD: begin
                a_ld = 1'b1;
                b_ld = 1'b1;
                if (ir_op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND}) begin
                    mem_rd    = 1'b1;
                    addr_sel  = 1'b1;
                    b_src_sel = 1'b1;
                end
                state_d = (ir_op == OP_STA) ? S_MEMWR : S_ALU;
            end
            S_ALU: begin
                res_ld = 1'b1;
                czn_ld = 1'b1;
                case (ir_op)
                    // Function codes above PASS B are unused; fold them onto PASS B.
                    OP_ALUR: alu_op = (di_op[2:1] == 2'b11) ? ALU_PASSB : di_op[2:0];
                    OP_LDA: begin
                        a_zero = 1'b1;
                        alu_op = ALU_ADD;
                    end
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_AND:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
                state_d = S_WB;
            end
            S_WB: begin
                acc_wr  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                mem_wr   = 1'b1;
                addr_sel = 1'b1;
                state_d  = S_FETCH;
            end
            S_BR: begin
                pc_ld   = br_take;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset must silence every output immediately, not just at the next edge.
        if (!rst) begin
            pc_inc    = 1'b0;
            ir_ld     = 1'b0;
            mem_rd    = 1'b0;
            tr_ld     = 1'b0;
            a_ld      = 1'b0;
            b_ld      = 1'b0;
            res_ld    = 1'b0;
            czn_ld    = 1'b0;
            pc_ld     = 1'b0;
            mem_wr    = 1'b0;
            acc_wr    = 1'b0;
            addr_sel  = 1'b0;
            b_src_sel = 1'b0;
            a_zero    = 1'b0;
            alu_op    = ALU_ADD;
            halted    = 1'b0;
            illegal   = 1'b0;
        end
    end

`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    logic [RETIRE_W-1:0] retire_q, retire_d;
    logic                retire_ev;

    assign retire_ev = (state_d == S_FETCH) &&
                       (((state_q == S_DECODE) && (ir_op == OP_NOP)) ||
                        (state_q inside {S_WB, S_MEMWR, S_BR}));
    assign retire_d  = retire_ev ? retire_q + {{(RETIRE_W-1){1'b0}}, 1'b1} : retire_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) retire_q <= '0;
        else      retire_q <= retire_d;
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-state output vectors, branches, reset, halt and retire wrap.
module tb_control_unit;

`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    localparam bit RET_EN = 1'b1;
`else
    localparam bit RET_EN = 1'b0;
`endif

    localparam logic [19:0] PC_INC = 20'h80000, PC_LD  = 20'h40000, IR_LD  = 20'h20000;
    localparam logic [19:0] TR_LD  = 20'h10000, A_LD   = 20'h08000, B_LD   = 20'h04000;
    localparam logic [19:0] RES_LD = 20'h02000, CZN_LD = 20'h01000, MEM_RD = 20'h00800;
    localparam logic [19:0] MEM_WR = 20'h00400, ACC_WR = 20'h00200, ADDR1  = 20'h00100;
    localparam logic [19:0] BSRC1  = 20'h00080, AZERO  = 20'h00040, HALTED = 20'h00002;
    localparam logic [19:0] ILLEG  = 20'h00001, NONE   = 20'h00000;
    localparam logic [19:0] E_FETCH  = MEM_RD | IR_LD | PC_INC;
    localparam logic [19:0] E_FETCH2 = MEM_RD | TR_LD | PC_INC;
    localparam logic [19:0] E_OPRD_M = A_LD | B_LD | MEM_RD | ADDR1 | BSRC1;
    localparam logic [19:0] E_OPRD_R = A_LD | B_LD;
    localparam logic [19:0] E_ALU    = RES_LD | CZN_LD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ir_op = 4'h0;
    logic [4:0] di_op = 5'h0;
    logic [2:0] czn = 3'h0;
    logic pc_inc, pc_ld, ir_ld, tr_ld, a_ld, b_ld, res_ld, czn_ld;
    logic mem_rd, mem_wr, acc_wr, addr_sel, b_src_sel, a_zero, b_zero, halted, illegal;
    logic [2:0]  alu_op;
    logic [3:0]  retire_cnt;
    logic [19:0] outs;

    int tests = 0;
    int fails = 0;
    int nret  = 0;

    control_unit #(.RETIRE_W(4)) dut (
        .clk(clk), .rst(rst), .ir_op(ir_op), .di_op(di_op), .czn(czn),
        .pc_inc(pc_inc), .pc_ld(pc_ld), .ir_ld(ir_ld), .tr_ld(tr_ld),
        .a_ld(a_ld), .b_ld(b_ld), .res_ld(res_ld), .czn_ld(czn_ld),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .acc_wr(acc_wr),
        .addr_sel(addr_sel), .b_src_sel(b_src_sel), .a_zero(a_zero), .b_zero(b_zero),
        .alu_op(alu_op), .halted(halted), .illegal(illegal), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {pc_inc, pc_ld, ir_ld, tr_ld, a_ld, b_ld, res_ld, czn_ld,
                   mem_rd, mem_wr, acc_wr, addr_sel, b_src_sel, a_zero, b_zero,
                   alu_op, halted, illegal};

    function automatic logic [19:0] alu(input logic [2:0] a);
        return {15'b0, a, 2'b00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] e);
        tests++;
        assert (outs === e) else begin
            fails++;
            $error("FAIL %s: outputs=%05h expected=%05h", tag, outs, e);
        end
        $display("[TB] %s outputs=%05h", tag, outs);
    endtask

    task automatic chk_ret(input string tag, input int n);
        logic [3:0] e;
        e = RET_EN ? 4'(n) : 4'h0;
        tests++;
        assert (retire_cnt === e) else begin
            fails++;
            $error("FAIL %s: retire_cnt=%0d expected=%0d", tag, retire_cnt, e);
        end
        $display("[TB] %s retire_cnt=%0d", tag, retire_cnt);
    endtask

    initial begin
        #2;
        chk("reset_outs", NONE);
        chk_ret("reset_retire", 0);
        @(posedge clk); #1;
        chk("reset_hold_outs", NONE);
        @(negedge clk); rst = 1'b1; #1;

        // NOP: FETCH, DECODE, FETCH
        ir_op = 4'h0;
        chk("nop_fetch", E_FETCH);
        step(); chk("nop_decode", NONE);
        step(); chk("nop_refetch", E_FETCH); nret++;
        chk_ret("nop_retire", nret);

        // ADD, flags don't care
        ir_op = 4'h3; czn = 3'b111;
        step(); chk("add_decode", NONE);
        step(); chk("add_fetch2", E_FETCH2);
        step(); chk("add_oprd", E_OPRD_M);
        step(); chk("add_alu", E_ALU | alu(3'b000));
        step(); chk("add_wb", ACC_WR);
        step(); chk("add_fetch", E_FETCH); nret++;
        chk_ret("add_retire", nret);

        // JZ taken, then not taken
        ir_op = 4'h9; czn = 3'b010;
        step(); chk("jz_t_decode", NONE);
        step(); chk("jz_t_fetch2", E_FETCH2);
        step(); chk("jz_t_br", PC_LD);
        step(); chk("jz_t_fetch", E_FETCH); nret++;
        czn = 3'b101;
        step(); chk("jz_n_decode", NONE);
        step(); chk("jz_n_fetch2", E_FETCH2);
        step(); chk("jz_n_br", NONE);
        step(); chk("jz_n_fetch", E_FETCH); nret++;
        chk_ret("jz_retire", nret);

        // JC taken with C set
        ir_op = 4'h8; czn = 3'b100;
        step(); step();
        step(); chk("jc_t_br", PC_LD);
        step(); nret++;

        // ALUR with di_op=111 folds to PASS B
        ir_op = 4'h6; di_op = 5'b11111;
        step(); chk("alur_decode", NONE);
        step(); chk("alur_oprd", E_OPRD_R);
        step(); chk("alur_alu_111", E_ALU | alu(3'b101));
        step(); chk("alur_wb", ACC_WR);
        step(); nret++;
        di_op = 5'b00011;
        step(); step();
        step(); chk("alur_alu_or", E_ALU | alu(3'b011));
        step(); step(); nret++;
        di_op = 5'b00110;
        step(); step();
        step(); chk("alur_alu_110", E_ALU | alu(3'b101));
        step(); step(); nret++;
        chk_ret("alur_retire", nret);

        // STA: 5 cycles ending in MEMWR
        ir_op = 4'h2;
        step(); step();
        step(); chk("sta_oprd", E_OPRD_R);
        step(); chk("sta_memwr", MEM_WR | ADDR1);
        step(); chk("sta_fetch", E_FETCH); nret++;

        // LDA: zero A, ADD
        ir_op = 4'h1;
        step(); step();
        step(); chk("lda_oprd", E_OPRD_M);
        step(); chk("lda_alu", E_ALU | AZERO | alu(3'b000));
        step(); step(); nret++;
        chk_ret("lda_retire", nret);

        // Illegal opcode 1011
        ir_op = 4'hB;
        step(); chk("illegal_decode", ILLEG);
        step(); chk("illegal_fetch", E_FETCH);
        chk_ret("illegal_retire", nret);

        // SUB interrupted by reset during ALU
        ir_op = 4'h4;
        step(); step(); step();
        step(); chk("sub_alu", E_ALU | alu(3'b001));
        #2; rst = 1'b0; #1;
        chk("sub_reset_outs", NONE);
        chk_ret("sub_reset_retire", 0);
        @(negedge clk); rst = 1'b1; #1;
        chk("post_reset_fetch", E_FETCH);
        chk_ret("post_reset_retire", 0);

        // 16 NOPs: counter wraps 15 -> 0
        ir_op = 4'h0;
        for (int i = 0; i < 15; i++) begin
            step(); step();
        end
        chk_ret("nop15_retire", 15);
        step(); step();
        chk_ret("nop16_wrap", 0);

        // HLT: halted held, no strobes
        ir_op = 4'hF;
        step(); chk("hlt_decode", NONE);
        for (int i = 0; i < 100; i++) begin
            step();
            if (outs !== HALTED || i == 0 || i == 99) chk($sformatf("hlt_hold_%0d", i), HALTED);
        end
        #2; rst = 1'b0; #1;
        chk("hlt_reset_outs", NONE);
        @(negedge clk); rst = 1'b1; #1;
        chk("hlt_post_reset_fetch", E_FETCH);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
